// File: rtl/sr_pkg.sv
// Shared definitions for the recirculating hex-digit shift register (read and write controllers).
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } sr_state_e;

    localparam int BITS_PER_DIGIT = 4;

    // Segment order: bit 6 = a, bit 5 = b, ... bit 0 = g; active high.
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to seven-segment glyph decode, segment order as in sr_pkg.
module hex_to_seg7
    import sr_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_GLYPH[nibble];

endmodule

// File: rtl/sr_nibble_reader.sv
// Read side of the recirculating shift register: waits for a requested digit to stream past and returns it.
// Optional registered 7-segment output under SR_SEG7_EN; request held off while a response awaits rsp_ready.
module sr_nibble_reader
    import sr_pkg::*;
#(
    parameter int LENGTH = 40,
    parameter int DIG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sr_data,
    input  logic             frame_sync,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIG_W-1:0] req_digit,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_nibble,
    output logic             rsp_err
`ifdef SR_SEG7_EN
    ,
    output logic [6:0]       rsp_seg
`endif
);

    localparam int NDIGITS = LENGTH / BITS_PER_DIGIT;
    localparam int PW      = $clog2(LENGTH);

    logic [PW-1:0]    pos_q, pos_d, eff_pos;
    sr_state_e        state_q, state_d;
    logic [DIG_W-1:0] digit_q, digit_d;
    logic [1:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       nib_q, nib_d;
    logic [3:0]       rsp_nibble_q, rsp_nibble_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             at_target;

    // A frame_sync cycle is by definition bit 0 of digit 0, whatever the counter says.
    always_comb begin
        eff_pos   = frame_sync ? '0 : pos_q;
        pos_d     = (int'(eff_pos) == LENGTH - 1) ? '0 : eff_pos + PW'(1);
        at_target = (int'(eff_pos) == BITS_PER_DIGIT * int'(digit_q));
    end

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        bit_cnt_d    = bit_cnt_q;
        nib_d        = nib_q;
        rsp_nibble_d = rsp_nibble_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    digit_d = req_digit;
                    if (int'(req_digit) >= NDIGITS) begin
                        rsp_err_d    = 1'b1;
                        rsp_nibble_d = 4'h0;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (at_target) begin
                    nib_d     = {3'b000, sr_data};
                    bit_cnt_d = 2'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Realignment invalidates the partial digit; digit 0 restarts on this very bit.
                if (frame_sync) begin
                    if (at_target) begin
                        nib_d     = {3'b000, sr_data};
                        bit_cnt_d = 2'd1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    nib_d[bit_cnt_q] = sr_data;
                    bit_cnt_d        = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
                        rsp_nibble_d = nib_d;
                        rsp_err_d    = 1'b0;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q        <= '0;
            state_q      <= ST_IDLE;
            digit_q      <= '0;
            bit_cnt_q    <= 2'd0;
            nib_q        <= 4'h0;
            rsp_nibble_q <= 4'h0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            pos_q        <= pos_d;
            state_q      <= state_d;
            digit_q      <= digit_d;
            bit_cnt_q    <= bit_cnt_d;
            nib_q        <= nib_d;
            rsp_nibble_q <= rsp_nibble_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_nibble = rsp_nibble_q;
    assign rsp_err    = rsp_err_q;

`ifdef SR_SEG7_EN
    logic [6:0] glyph;
    logic [6:0] seg_q, seg_d;

    // Decoded from the value being loaded so the glyph lines up with rsp_nibble.
    hex_to_seg7 u_hex_to_seg7 (
        .nibble (rsp_nibble_d),
        .seg    (glyph)
    );

    always_comb begin
        seg_d = rsp_err_d ? 7'b0000000 : glyph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'b0000000;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign rsp_seg = seg_q;
`endif

endmodule

// File: tb/tb_sr_nibble_reader.sv
// Self-checking bench for sr_nibble_reader: table vectors, corner sequences, randomized transactions.
module tb_sr_nibble_reader;

    localparam int LENGTH = 40;
    localparam int DIG_W  = 4;
    localparam int NDIG   = LENGTH / 4;

    typedef struct {
        int pos;
        int digit;
        int nib;
        int err;
        int lat;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sr_data;
    logic             frame_sync;
    logic             req_valid;
    logic             req_ready;
    logic [DIG_W-1:0] req_digit;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_nibble;
    logic             rsp_err;
`ifdef SR_SEG7_EN
    logic [6:0]       rsp_seg;
    logic [6:0]       glyph_ref [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
`endif

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         tb_pos = 0;
    logic [3:0] store [NDIG];
    vec_t       vecs [9];

    always #5 clk = ~clk;

    sr_nibble_reader #(
        .LENGTH (LENGTH),
        .DIG_W  (DIG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sr_data    (sr_data),
        .frame_sync (frame_sync),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_digit  (req_digit),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_nibble (rsp_nibble),
        .rsp_err    (rsp_err)
`ifdef SR_SEG7_EN
        ,
        .rsp_seg    (rsp_seg)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Write-side model: the register tail emits digit (pos/4), bit (pos%4), frame_sync at pos 0.
    task automatic drive_stream();
        sr_data    = store[tb_pos / 4][tb_pos % 4];
        frame_sync = (tb_pos == 0);
    endtask

    task automatic step(input bit resync);
        @(posedge clk);
        #1;
        tb_pos = resync ? 0 : (tb_pos + 1) % LENGTH;
        drive_stream();
    endtask

    task automatic wait_pos(input int tgt);
        int n;
        n = 0;
        while (tb_pos != tgt && n < 2 * LENGTH) begin
            step(1'b0);
            n++;
        end
    endtask

    // Accept in the cycle at stream position p: the first later cycle at 4*d starts capture,
    // four more edges bring the response.
    function automatic int exp_lat(input int p, input int d);
        if (d >= NDIG) return 1;
        for (int k = 1; k <= LENGTH; k++) begin
            if ((p + k) % LENGTH == 4 * d) return k + 4;
        end
        return -1;
    endfunction

    task automatic run_txn(input int d, input int hold, input int exp_nib, input int exp_err,
                           input int exp_lt, input string tag, input int rs);
        int lat;
        chk({tag, " req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_digit = DIG_W'(d);
        rsp_ready = 1'b1;
        step(rs == 1);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            rsp_ready = lat[0];
            step(rs == lat + 1);
            lat++;
        end
        rsp_ready = 1'b0;
        chk({tag, " latency"}, lat, exp_lt);
        chk({tag, " nibble"}, rsp_nibble, exp_nib);
        chk({tag, " err"}, rsp_err, exp_err);
`ifdef SR_SEG7_EN
        chk({tag, " seg"}, rsp_seg, exp_err != 0 ? 7'b0 : glyph_ref[exp_nib]);
`endif
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_digit = DIG_W'(i);
            step(1'b0);
            chk({tag, " hold valid"}, rsp_valid, 1);
            chk({tag, " hold nibble"}, rsp_nibble, exp_nib);
            chk({tag, " hold req_ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step(1'b0);
        rsp_ready = 1'b0;
        chk({tag, " valid drop"}, rsp_valid, 0);
        chk({tag, " ready back"}, req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, gap, hold, en;

        vecs[0] = '{pos: 7,  digit: 2,  nib: 4, err: 0, lat: 5};
        vecs[1] = '{pos: 35, digit: 9,  nib: 3, err: 0, lat: 5};
        vecs[2] = '{pos: 36, digit: 9,  nib: 3, err: 0, lat: 44};
        vecs[3] = '{pos: 10, digit: 12, nib: 0, err: 1, lat: 1};
        vecs[4] = '{pos: 20, digit: 0,  nib: 3, err: 0, lat: 24};
        vecs[5] = '{pos: 0,  digit: 5,  nib: 9, err: 0, lat: 24};
        vecs[6] = '{pos: 39, digit: 15, nib: 0, err: 1, lat: 1};
        vecs[7] = '{pos: 39, digit: 0,  nib: 3, err: 0, lat: 5};
        vecs[8] = '{pos: 30, digit: 7,  nib: 6, err: 0, lat: 42};

        store = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'h5, 4'h3};
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_digit = '0;
        rsp_ready = 1'b0;
        tb_pos    = 0;
        drive_stream();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_nibble", rsp_nibble, 0);
        chk("reset rsp_err", rsp_err, 0);
`ifdef SR_SEG7_EN
        chk("reset rsp_seg", rsp_seg, 0);
`endif
        rst_n  = 1'b1;
        tb_pos = 0;
        drive_stream();

        foreach (vecs[i]) begin
            wait_pos(vecs[i].pos);
            run_txn(vecs[i].digit, 0, vecs[i].nib, vecs[i].err, vecs[i].lat,
                    $sformatf("vec%0d", i), 0);
        end

        // Response held off for 20 cycles while a competing request is presented.
        wait_pos(10);
        run_txn(4, 20, 5, 0, 10, "hold", 0);

        // Realignment pulse in the middle of digit 0's capture.
        wait_pos(38);
        run_txn(0, 0, 3, 0, 8, "fsync", 4);

        // Reset while waiting for digit 7; outputs clear at once, pending request dropped.
        wait_pos(0);
        req_valid = 1'b1;
        req_digit = DIG_W'(7);
        step(1'b0);
        req_valid = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid-reset rsp_valid", rsp_valid, 0);
        chk("mid-reset rsp_nibble", rsp_nibble, 0);
        chk("mid-reset rsp_err", rsp_err, 0);
        step(1'b0);
        step(1'b0);
        rst_n  = 1'b1;
        tb_pos = 0;
        drive_stream();
        run_txn(3, 0, 1, 0, 16, "post_rst", 0);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NDIG; i++) store[i] = 4'($urandom_range(0, 15));
            drive_stream();
            gap = $urandom_range(0, 5);
            repeat (gap) step(1'b0);
            d    = $urandom_range(0, 15);
            hold = $urandom_range(0, 3);
            en   = (d < NDIG) ? int'(store[d]) : 0;
            run_txn(d, hold, en, (d >= NDIG) ? 1 : 0, exp_lat(tb_pos, d),
                    $sformatf("rnd%0d", t), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
